opb_register_simulink2ppc: RTL and testbench
============================================

# opb_register_simulink2ppc

Memory-mapped OPB slave that lets the PowerPC read a 32-bit value produced by user fabric logic, with a sticky new-data flag and an overrun counter. It is the read-direction counterpart of the PPC-to-fabric software register: user logic strobes a word in, and software polls the block over OPB. It sits on the OPB bus beside the other software registers, within a 256-byte window. The whole block runs on the single OPB clock, so user logic driving it must already be synchronous to OPB_Clk.

## Interface
- C_BASEADDR, 32'h01003800, first byte address of the window
- C_HIGHADDR, 32'h010038FF, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_FAMILY, "virtex5", target family string (informational)

- OPB_Clk  in  1  only clock; all logic on its rising edge
- OPB_Rst  in  1  reset, synchronous, active-high
- OPB_ABus  in  [0:31]  byte address, bit 0 = MSB
- OPB_BE  in  [0:3]  byte enables, BE[0] ↔ DBus[0:7]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; all-zero outside the ack cycle (wired-OR bus)
- Sl_xferAck  out  1  one-cycle transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- user_data_in  in  [31:0]  value from fabric
- user_data_valid  in  1  capture strobe, one word per high cycle

## Operation
- Address hit: OPB_select=1 and C_BASEADDR ≤ OPB_ABus ≤ C_HIGHADDR. Word index is OPB_ABus[24:29].
- Word 0 (DATA): read returns the latched word. Writes are acked and ignored.
- Word 1 (STATUS): read returns {new_flag at data bit 31, 15'b0, overrun_cnt[15:0]}. Data bit 31 maps to Sl_DBus[0]. A write with any BE set clears overrun_cnt. Writes do not affect new_flag.
- Words 2..63: reads return 0; writes are acked and ignored.
- Integer bit n maps to OPB bus bit 31-n.
- Capture: when user_data_valid=1, latch user_data_in and set new_flag. If new_flag was already set and no STATUS read clears it in the same cycle, increment overrun_cnt, saturating at 16'hFFFF.
- A STATUS read (in its ack cycle) clears new_flag.
- Simultaneous capture and STATUS read in the same cycle: set wins. new_flag ends at 1, and no overrun is counted.
- Simultaneous capture and DATA read in the same cycle: the read returns the previous latched word, and the new word is latched.
- Simultaneous capture and STATUS-write clear in the same cycle: the counter ends at 0. The clear wins.

## Timing
- Two-state acknowledge FSM:
  - IDLE → ACK when an address hit is sampled.
  - ACK → IDLE unconditionally.
  - Sl_xferAck=1 only in ACK, so ack comes one cycle after select is sampled.
  - A hit is not re-taken in the cycle of ACK itself. Back-to-back transfers therefore acknowledge at most every other cycle.
- Sl_DBus is registered, loaded in the IDLE→ACK transition from register state at that edge, and zeroed otherwise.
- Reset values: Sl_DBus=0, Sl_xferAck=0, latched data=0, new_flag=0, overrun_cnt=0, FSM=IDLE.
- Reset asserted mid-transfer: the FSM returns to IDLE next edge, ack is dropped, and no side effects occur. The master's timeout handles it.
- OPB_select dropped while in ACK: no effect; the transfer completes.

## Structure
- Package opb_s2p_pkg holds:
  - word-index constants (DATA=0, STATUS=1)
  - STATUS bit positions (NEW_BIT=31, CNT_LSB=0, CNT_W=16)
  - the OPB bus-to-integer bit-reverse function
- Sub-module opb_s2p_capture contains the latch, new_flag and saturating overrun counter, driven by capture, rd_status_clr and cnt_clr strobes. The top level holds the decode, ack FSM and read mux.

## Test plan
- Reset, then read DATA and STATUS → Sl_DBus=0 on each ack. Ack arrives exactly 1 cycle after select. Sl_DBus=0 in all non-ack cycles.
- Strobe 32'hDEADBEEF, then read DATA and STATUS → DATA returns 32'hDEADBEEF. STATUS returns bit31=1, cnt=0. A second STATUS read returns 0.
- Three strobes with no read in between → STATUS cnt=2, flag=1. Write STATUS with BE=4'b0001 → next STATUS read gives cnt=0, flag=0.
- Capture in the same cycle as a STATUS read ack → that read shows the old flag. The next read shows flag=1 and cnt unchanged.
- 70000 strobes without a read → cnt saturates at 16'hFFFF. Address C_HIGHADDR+4 with select held → no ack ever.
- OPB_Rst pulsed during the ACK cycle → ack is gone next cycle and all registers are 0.

Source files
------------

// File: rtl/opb_s2p_pkg.sv
// opb_s2p_pkg: shared word map, STATUS layout, ack FSM states and OPB bit-order helper
package opb_s2p_pkg;
   localparam logic [5:0] WORD_DATA   = 6'd0;
   localparam logic [5:0] WORD_STATUS = 6'd1;
   localparam int NEW_BIT = 31;
   localparam int CNT_LSB = 0;
   localparam int CNT_W   = 16;
   typedef enum logic {S_IDLE, S_ACK} ack_state_t;
   // OPB numbers bit 0 as MSB; integer bit n lives at bus bit 31-n
   function automatic logic [31:0] bus_to_int(input logic [0:31] b);
      logic [31:0] r;
      for (int n = 0; n < 32; n++) r[n] = b[31-n];
      return r;
   endfunction
endpackage

// File: rtl/opb_s2p_capture.sv
// opb_s2p_capture: fabric word latch with sticky new flag and saturating overrun counter
//   clk, rst      : OPB clock, synchronous active-high reset
//   capture, din  : one-cycle strobe and word from fabric
//   rd_status_clr : STATUS read ack; clears new_flag unless a capture coincides
//   cnt_clr       : STATUS write ack; zeroes the counter, beating a coincident overrun
//   data, new_flag, cnt : register state for the read mux
module opb_s2p_capture
   import opb_s2p_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             capture,
   input  logic [31:0]      din,
   input  logic             rd_status_clr,
   input  logic             cnt_clr,
   output logic [31:0]      data,
   output logic             new_flag,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk)
      if (rst) begin
         data     <= '0;
         new_flag <= 1'b0;
         cnt      <= '0;
      end else begin
         if (capture) data <= din;
         new_flag <= capture | (new_flag & ~rd_status_clr);
         cnt      <= cnt_clr ? '0 : (capture & new_flag & ~rd_status_clr & ~&cnt) ? cnt + 1'b1 : cnt;
      end
endmodule

// File: rtl/opb_register_simulink2ppc.sv
// opb_register_simulink2ppc: OPB slave exposing a fabric-written word plus new flag / overrun count to the PPC
//   OPB_Clk, OPB_Rst        : only clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW/select/seqAddr : OPB master side (seqAddr and write data ignored)
//   Sl_DBus, Sl_xferAck     : registered read data (zero outside ack) and one-cycle ack
//   Sl_errAck/retry/toutSup : tied low
//   user_data_in/valid      : fabric word and capture strobe
module opb_register_simulink2ppc
   import opb_s2p_pkg::*;
#(
   parameter logic [31:0]  C_BASEADDR   = 32'h01003800,
   parameter logic [31:0]  C_HIGHADDR   = 32'h010038FF,
   parameter int           C_OPB_AWIDTH = 32,
   parameter int           C_OPB_DWIDTH = 32,
   parameter logic [127:0] C_FAMILY     = "virtex5"
)(
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
   input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
   input  logic                      OPB_RNW,
   input  logic                      OPB_select,
   input  logic                      OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
   output logic                      Sl_xferAck,
   output logic                      Sl_errAck,
   output logic                      Sl_retry,
   output logic                      Sl_toutSup,
   input  logic [31:0]               user_data_in,
   input  logic                      user_data_valid
);
   ack_state_t state, state_nx;
   logic [31:0] addr, rd_word, status_word, data;
   logic [5:0] word, word_q;
   logic [CNT_W-1:0] cnt;
   logic hit, rnw_q, be_q, new_flag, rd_status_clr, cnt_clr, unused;
   assign unused     = ^{OPB_seqAddr, OPB_DBus, C_FAMILY};
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;
   assign addr = bus_to_int(OPB_ABus);
   assign word = addr[7:2];
   assign hit  = OPB_select && addr >= C_BASEADDR && addr <= C_HIGHADDR;
   // a hit seen while already in ACK is ignored, so acks are at least two cycles apart
   always_comb begin
      status_word = '0;
      status_word[NEW_BIT] = new_flag;
      status_word[CNT_LSB +: CNT_W] = cnt;
      rd_word  = word == WORD_DATA ? data : word == WORD_STATUS ? status_word : '0;
      state_nx = state == S_IDLE && hit ? S_ACK : S_IDLE;
   end
   // transfer attributes are held so the ack-cycle side effects survive select dropping
   always_ff @(posedge OPB_Clk)
      if (OPB_Rst) begin
         state   <= S_IDLE;
         Sl_DBus <= '0;
         word_q  <= '0;
         rnw_q   <= 1'b0;
         be_q    <= 1'b0;
      end else begin
         state   <= state_nx;
         Sl_DBus <= state_nx == S_ACK && OPB_RNW ? rd_word : '0;
         if (state_nx == S_ACK) begin
            word_q <= word;
            rnw_q  <= OPB_RNW;
            be_q   <= |OPB_BE;
         end
      end
   assign Sl_xferAck    = state == S_ACK;
   assign rd_status_clr = Sl_xferAck && rnw_q && word_q == WORD_STATUS;
   assign cnt_clr       = Sl_xferAck && !rnw_q && be_q && word_q == WORD_STATUS;
   opb_s2p_capture u_capture (
      .clk           (OPB_Clk),
      .rst           (OPB_Rst),
      .capture       (user_data_valid),
      .din           (user_data_in),
      .rd_status_clr (rd_status_clr),
      .cnt_clr       (cnt_clr),
      .data          (data),
      .new_flag      (new_flag),
      .cnt           (cnt)
   );
endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// tb_opb_register_simulink2ppc: randomized and directed check of the OPB read register against a behavioural model
module tb_opb_register_simulink2ppc;
   localparam logic [31:0] BASE = 32'h01003800;
   localparam logic [31:0] HIGH = 32'h010038FF;
   logic        OPB_Clk = 1'b0, OPB_Rst = 1'b1;
   logic [0:31] OPB_ABus = '0, OPB_DBus = '0;
   logic [0:3]  OPB_BE = '0;
   logic        OPB_RNW = 1'b1, OPB_select = 1'b0, OPB_seqAddr = 1'b0;
   logic [0:31] Sl_DBus;
   logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
   logic [31:0] user_data_in = '0;
   logic        user_data_valid = 1'b0;
   int n_cmp = 0, n_bad = 0;
   logic [31:0] m_data = '0, e_dbus = '0, v;
   bit m_flag = 0, e_ack = 0, t_rnw = 0, t_be = 0;
   int m_cnt = 0, t_word = 0;

   always #5 OPB_Clk = ~OPB_Clk;

   opb_register_simulink2ppc dut (
      .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
      .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
      .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry),
      .Sl_toutSup(Sl_toutSup), .user_data_in(user_data_in), .user_data_valid(user_data_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // one clock: drive inputs, advance model at the edge, compare just after it
   task automatic step(input bit cap, input logic [31:0] din, input bit sel, input logic [31:0] a,
                       input bit rnw, input logic [3:0] be, input bit r);
      bit hit, st_rd, st_wr;
      int w;
      logic [31:0] rd_val;
      user_data_valid = cap; user_data_in = din; OPB_select = sel; OPB_ABus = a;
      OPB_RNW = rnw; OPB_BE = be; OPB_Rst = r; OPB_DBus = $urandom;
      @(posedge OPB_Clk);
      if (r) begin
         m_data = 0; m_flag = 0; m_cnt = 0; e_ack = 0; e_dbus = 0;
      end else begin
         hit    = sel && a >= BASE && a <= HIGH;
         w      = hit ? int'((a - BASE) / 4) : 0;
         st_rd  = e_ack && t_rnw && t_word == 1;
         st_wr  = e_ack && !t_rnw && t_word == 1 && t_be;
         rd_val = w == 0 ? m_data : w == 1 ? (m_flag ? 32'h8000_0000 : 32'h0) + 32'(m_cnt) : 32'h0;
         e_dbus = (!e_ack && hit && rnw) ? rd_val : 32'h0;
         if (!e_ack && hit) begin t_rnw = rnw; t_word = w; t_be = be != 0; end
         if (cap && m_flag && !st_rd && m_cnt < 65535) m_cnt++;
         if (cap) m_data = din;
         m_flag = cap || (m_flag && !st_rd);
         if (st_wr) m_cnt = 0;
         e_ack = !e_ack && hit;
      end
      #1;
      chk("ack", {31'b0, Sl_xferAck}, {31'b0, e_ack});
      chk("dbus", Sl_DBus, e_dbus);
      chk("tied", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
      @(negedge OPB_Clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 1, 4'h0, 0);
   endtask

   task automatic strobe(input logic [31:0] d);
      step(1, d, 0, 0, 1, 4'h0, 0);
   endtask

   // select held through the ack cycle, as a real master does; c0/c1 strobe on select / ack cycle
   task automatic rd(input logic [31:0] a, input bit c0, input bit c1, input logic [31:0] d, output logic [31:0] r);
      step(c0, d, 1, a, 1, 4'hF, 0);
      r = Sl_DBus;
      step(c1, d, 1, a, 1, 4'hF, 0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] be, input bit c1, input logic [31:0] d);
      step(0, 0, 1, a, 0, be, 0);
      step(c1, d, 1, a, 0, be, 0);
   endtask

   initial begin
      logic [31:0] a;
      step(0, 0, 0, 0, 1, 4'h0, 1);
      step(0, 0, 0, 0, 1, 4'h0, 1);
      chk("rst_ack", {31'b0, Sl_xferAck}, 32'h0);
      rd(BASE, 0, 0, 0, v);     chk("rst_data", v, 32'h0);
      rd(BASE + 4, 0, 0, 0, v); chk("rst_status", v, 32'h0);
      strobe(32'hDEADBEEF);
      rd(BASE, 0, 0, 0, v);     chk("data_beef", v, 32'hDEADBEEF);
      rd(BASE + 4, 0, 0, 0, v); chk("status_new", v, 32'h8000_0000);
      rd(BASE + 4, 0, 0, 0, v); chk("status_cleared", v, 32'h0);
      strobe(32'h1); strobe(32'h2); strobe(32'h3);
      rd(BASE + 4, 0, 0, 0, v); chk("overrun2", v, 32'h8000_0002);
      wr(BASE + 4, 4'b0001, 0, 0);
      rd(BASE + 4, 0, 0, 0, v); chk("cnt_clear", v, 32'h0);
      rd(BASE + 4, 0, 1, 32'hA5A5_0001, v); chk("cap_in_ack_old", v, 32'h0);
      rd(BASE + 4, 0, 0, 0, v); chk("cap_in_ack_set", v, 32'h8000_0000);
      strobe(32'hA5A5_0002);
      rd(BASE + 4, 0, 1, 32'hA5A5_0002, v); chk("cap_ack_flag1", v, 32'h8000_0000);
      rd(BASE + 4, 0, 0, 0, v); chk("set_wins_no_ovr", v, 32'h8000_0000);
      rd(BASE, 1, 0, 32'h1111_2222, v); chk("data_old_on_cap", v, 32'hA5A5_0002);
      rd(BASE, 0, 0, 0, v); chk("data_new", v, 32'h1111_2222);
      strobe(32'h5); strobe(32'h6);
      wr(BASE + 4, 4'b1000, 1, 32'h7);
      rd(BASE + 4, 0, 0, 0, v); chk("clear_wins", v, 32'h8000_0000);
      rd(BASE + 8 + 4 * $urandom_range(0, 61), 0, 0, 0, v); chk("unmapped", v, 32'h0);
      repeat (6) begin
         step(0, 0, 1, HIGH + 4, 1, 4'hF, 0);
         chk("oor_high", {31'b0, Sl_xferAck}, 32'h0);
      end
      repeat (4) begin
         step(0, 0, 1, BASE - 4, 1, 4'hF, 0);
         chk("oor_low", {31'b0, Sl_xferAck}, 32'h0);
      end
      idle(1);
      repeat (70000) strobe($urandom);
      rd(BASE + 4, 0, 0, 0, v); chk("saturate", v, 32'h8000_FFFF);
      strobe(32'h1234_5678);
      step(0, 0, 1, BASE, 1, 4'hF, 0);
      chk("pre_rst_ack", {31'b0, Sl_xferAck}, 32'h1);
      step(0, 0, 1, BASE, 1, 4'hF, 1);
      chk("rst_drops_ack", {31'b0, Sl_xferAck}, 32'h0);
      chk("rst_drops_dbus", Sl_DBus, 32'h0);
      rd(BASE, 0, 0, 0, v);     chk("rst_mid_data", v, 32'h0);
      rd(BASE + 4, 0, 0, 0, v); chk("rst_mid_status", v, 32'h0);
      repeat (3000) begin
         case ($urandom_range(0, 5))
            0:       a = BASE + $urandom_range(0, 3);
            1:       a = BASE + 4 + $urandom_range(0, 3);
            2, 3:    a = BASE + $urandom_range(0, 255);
            4:       a = HIGH + 1 + $urandom_range(0, 64);
            default: a = BASE - 1 - $urandom_range(0, 64);
         endcase
         step($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 1, a,
              $urandom_range(0, 1) == 1, 4'($urandom), $urandom_range(0, 299) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
